// File: rtl/spi_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_ctrl
//  Purpose  : Receive-side SPI transfer controller. Sequences one transfer
//             of data frames plus an optional CRC frame, buffers data frames
//             in a first-word-fall-through FIFO, raises RXNE / overrun /
//             CRC-error status and pulses done at end of transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_rx,
  input  logic          spi_rx_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    df,
  input  logic [12:0]   spi_tnum_max,
  input  logic          crc_en,
  input  logic          frame_vld,
  input  logic [31:0]   frame_data,
  input  logic [31:0]   crc_calc,
  input  logic          rd_en,
  input  logic          ovr_clr,
  input  logic          crcerr_clr,
  output logic [31:0]   rd_data,
  output logic          rxne,
  output logic [CW-1:0] fifo_cnt,
  output logic          ovr,
  output logic          crcerr,
  output logic          busy,
  output logic          done
);

  localparam int            C_AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  // Transfer parameters captured at start so later input changes are harmless
  logic [1:0]      r_df;
  logic            r_crc_en;
  logic [12:0]     r_tnum;
  logic [12:0]     r_fcnt;
  logic [12:0]     w_fcnt_inc;
  logic            w_last;

  // FIFO storage and bookkeeping
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_wr;

  // Status
  logic            r_ovr;
  logic            r_crcerr;
  logic            r_busy;
  logic            r_done;
  logic            w_crc_chk;
  logic            w_crc_bad;
  logic [31:0]     w_mask;

  assign w_fcnt_inc = r_fcnt + 13'd1;
  assign w_last     = (w_fcnt_inc == r_tnum);

  // A frame arriving alongside abort is dropped entirely
  assign w_push    = (r_state == S_DATA) && frame_vld && !abort;
  assign w_crc_chk = (r_state == S_CRC)  && frame_vld && !abort;

  assign w_full  = (r_cnt == C_FULL);
  assign w_empty = (r_cnt == '0);
  assign w_pop   = rd_en && !w_empty;
  // When full, a simultaneous pop frees the slot the push writes into
  assign w_wr    = w_push && (!w_full || w_pop);

  // State register
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state decode; abort wins over any frame in DATA or CRC
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_DATA;
      S_DATA: begin
        if (abort)                    w_next = S_IDLE;
        else if (frame_vld && w_last) w_next = r_crc_en ? S_CRC : S_DONE;
      end
      S_CRC: begin
        if (abort)          w_next = S_IDLE;
        else if (frame_vld) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch transfer setup on start and count accepted data frames
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      r_df     <= 2'b00;
      r_crc_en <= 1'b0;
      r_tnum   <= 13'd0;
      r_fcnt   <= 13'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_df     <= df;
      r_crc_en <= crc_en;
      r_tnum   <= (spi_tnum_max == 13'd0) ? 13'd1 : spi_tnum_max;
      r_fcnt   <= 13'd0;
    end else if (w_push) begin
      r_fcnt   <= w_fcnt_inc;
    end
  end

  // FIFO storage write; contents are qualified by the count, so no reset
  always_ff @(posedge clk_rx) begin
    if (w_wr && !spi_rx_rst) r_mem[r_wptr] <= frame_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power of two
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // CRC comparison width follows the latched frame size
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (r_df)
      2'b00:   w_mask = 32'h0000_00FF;
      2'b01:   w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign w_crc_bad = |((frame_data ^ crc_calc) & w_mask);

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      r_ovr    <= 1'b0;
      r_crcerr <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovr <= 1'b1;
      else if (ovr_clr)               r_ovr <= 1'b0;
      if (w_crc_chk && w_crc_bad)     r_crcerr <= 1'b1;
      else if (crcerr_clr)            r_crcerr <= 1'b0;
    end
  end

  // Registered busy/done track the state being entered
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
    end
  end

  assign rd_data  = w_empty ? 32'h0 : r_mem[r_rptr];
  assign rxne     = !w_empty;
  assign fifo_cnt = r_cnt;
  assign ovr      = r_ovr;
  assign crcerr   = r_crcerr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rx_ctrl
//  Purpose  : Self-checking bench for spi_rx_ctrl: CRC vector table plus
//             hand-written transfer, overrun, abort and reset sequences,
//             with a queue scoreboard of expected FIFO contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_rx      = 1'b0;
  logic          spi_rx_rst  = 1'b0;
  logic          start       = 1'b0;
  logic          abort       = 1'b0;
  logic [1:0]    df          = 2'b00;
  logic [12:0]   spi_tnum_max = 13'd0;
  logic          crc_en      = 1'b0;
  logic          frame_vld   = 1'b0;
  logic [31:0]   frame_data  = 32'h0;
  logic [31:0]   crc_calc    = 32'h0;
  logic          rd_en       = 1'b0;
  logic          ovr_clr     = 1'b0;
  logic          crcerr_clr  = 1'b0;
  logic [31:0]   rd_data;
  logic          rxne;
  logic [CW-1:0] fifo_cnt;
  logic          ovr;
  logic          crcerr;
  logic          busy;
  logic          done;

  spi_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_rx      (clk_rx),
    .spi_rx_rst  (spi_rx_rst),
    .start       (start),
    .abort       (abort),
    .df          (df),
    .spi_tnum_max(spi_tnum_max),
    .crc_en      (crc_en),
    .frame_vld   (frame_vld),
    .frame_data  (frame_data),
    .crc_calc    (crc_calc),
    .rd_en       (rd_en),
    .ovr_clr     (ovr_clr),
    .crcerr_clr  (crcerr_clr),
    .rd_data     (rd_data),
    .rxne        (rxne),
    .fifo_cnt    (fifo_cnt),
    .ovr         (ovr),
    .crcerr      (crcerr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_rx = ~clk_rx;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  logic        m_ovr  = 1'b0;

  typedef struct {
    logic [1:0]  v_df;
    logic [31:0] v_calc;
    logic [31:0] v_frame;
    logic        v_err;
  } crc_vec_t;

  crc_vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic do_reset();
    spi_rx_rst = 1'b1;
    tick();
    spi_rx_rst = 1'b0;
    q.delete();
    m_ovr = 1'b0;
  endtask

  // Start a transfer, then scramble the setup inputs to prove they were latched
  task automatic start_xfer(input logic [1:0] d, input logic [12:0] t, input logic c);
    df = d; spi_tnum_max = t; crc_en = c; start = 1'b1;
    tick();
    start = 1'b0; df = ~d; spi_tnum_max = ~t; crc_en = ~c;
  endtask

  // One frame; when it is a data frame the scoreboard tracks push or overrun
  task automatic send_frame(input logic [31:0] d, input bit is_data);
    frame_vld = 1'b1; frame_data = d;
    tick();
    frame_vld = 1'b0; frame_data = 32'h0;
    if (is_data) begin
      if (q.size() >= DEPTH) m_ovr = 1'b1;
      else                   q.push_back(d);
    end
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] exp;
    exp = (q.size() != 0) ? q[0] : 32'h0;
    chk(name, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk({name, "_cnt"}, 32'(fifo_cnt), 32'(q.size()));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rd_data"}, rd_data, 32'h0);
    chk({name, "_flags"}, {24'h0, rxne, fifo_cnt, ovr, crcerr, busy, done}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'h0000_1234, 32'h0000_1234, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_1234, 32'h0000_1235, 1'b1};
    vecs[2] = '{2'b00, 32'h0000_FF34, 32'h0000_0034, 1'b0};
    vecs[3] = '{2'b00, 32'h0000_1234, 32'h0000_0035, 1'b1};
    vecs[4] = '{2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{2'b11, 32'hDEAD_BEEF, 32'h5EAD_BEEF, 1'b1};
    vecs[6] = '{2'b01, 32'hABCD_1234, 32'h0000_1234, 1'b0};

    // Reset with junk inputs active
    frame_vld = 1'b1; frame_data = 32'hFFFF_FFFF; start = 1'b1;
    do_reset();
    frame_vld = 1'b0; frame_data = 32'h0; start = 1'b0;
    tick();
    chk_all_zero("reset");

    // Basic transfer
    start_xfer(2'b00, 13'd3, 1'b0);
    chk("basic_busy", busy, 1'b1);
    send_frame(32'hA1, 1);
    chk("basic_rxne1", rxne, 1'b1);
    chk("basic_head", rd_data, 32'hA1);
    send_frame(32'hB2, 1);
    chk("basic_nodone", done, 1'b0);
    send_frame(32'hC3, 1);
    chk("basic_done", done, 1'b1);
    chk("basic_cnt", 32'(fifo_cnt), 32'd3);
    tick();
    chk("basic_done_end", done, 1'b0);
    chk("basic_busy_end", busy, 1'b0);
    pop_chk("basic_pop0");
    pop_chk("basic_pop1");
    pop_chk("basic_pop2");
    chk("basic_rxne0", rxne, 1'b0);
    chk("basic_rd0", rd_data, 32'h0);

    // CRC match then mismatch
    do_reset();
    start_xfer(2'b01, 13'd2, 1'b1);
    send_frame(32'hAAAA, 1);
    send_frame(32'hBBBB, 1);
    crc_calc = 32'h1234;
    send_frame(32'h1234, 0);
    chk("crc_ok_err", crcerr, 1'b0);
    chk("crc_ok_done", done, 1'b1);
    chk("crc_ok_cnt", 32'(fifo_cnt), 32'd2);
    tick();
    start_xfer(2'b01, 13'd2, 1'b1);
    send_frame(32'hCCCC, 1);
    send_frame(32'hDDDD, 1);
    send_frame(32'h1235, 0);
    chk("crc_bad_err", crcerr, 1'b1);
    chk("crc_bad_done", done, 1'b1);
    repeat (3) tick();
    chk("crc_sticky", crcerr, 1'b1);
    crcerr_clr = 1'b1;
    tick();
    crcerr_clr = 1'b0;
    chk("crc_clr", crcerr, 1'b0);
    for (int i = 0; i < 4; i++) pop_chk("crc_pop");

    // CRC width mask table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      start_xfer(vecs[i].v_df, 13'd1, 1'b1);
      send_frame(32'h55, 1);
      crc_calc = vecs[i].v_calc;
      send_frame(vecs[i].v_frame, 0);
      chk($sformatf("crcvec%0d_err", i), crcerr, vecs[i].v_err);
      chk($sformatf("crcvec%0d_done", i), done, 1'b1);
      chk($sformatf("crcvec%0d_cnt", i), 32'(fifo_cnt), 32'd1);
      pop_chk($sformatf("crcvec%0d_pop", i));
    end

    // Overrun, clear coincident with set, push+pop at full
    do_reset();
    start_xfer(2'b10, 13'd6, 1'b0);
    for (int i = 1; i <= 4; i++) send_frame(32'(i), 1);
    chk("ovr_none", ovr, 1'b0);
    chk("ovr_cnt4", 32'(fifo_cnt), 32'd4);
    send_frame(32'd5, 1);
    chk("ovr_set", ovr, m_ovr);
    chk("ovr_cnt_hold", 32'(fifo_cnt), 32'd4);
    ovr_clr = 1'b1;
    send_frame(32'd6, 1);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", ovr, 1'b1);
    chk("ovr_done", done, 1'b1);
    for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", ovr, 1'b0);
    start_xfer(2'b00, 13'd5, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(32'h11 + 32'(i), 1);
    chk("pp_head", rd_data, q[0]);
    frame_vld = 1'b1; frame_data = 32'h15; rd_en = 1'b1;
    tick();
    frame_vld = 1'b0; frame_data = 32'h0; rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(32'h15);
    chk("pp_cnt", 32'(fifo_cnt), 32'd4);
    chk("pp_no_ovr", ovr, 1'b0);
    chk("pp_done", done, 1'b1);
    for (int i = 0; i < 4; i++) pop_chk("pp_pop");

    // Abort with a coincident frame
    do_reset();
    start_xfer(2'b00, 13'd4, 1'b0);
    send_frame(32'h01, 1);
    frame_vld = 1'b1; frame_data = 32'h02; abort = 1'b1;
    tick();
    frame_vld = 1'b0; frame_data = 32'h0; abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_cnt", 32'(fifo_cnt), 32'd1);
    chk("abort_nodone", done, 1'b0);
    tick();
    chk("abort_nodone2", done, 1'b0);
    send_frame(32'h03, 0);
    chk("abort_ignored", 32'(fifo_cnt), 32'd1);
    start_xfer(2'b00, 13'd2, 1'b0);
    send_frame(32'h04, 1);
    chk("restart_nodone", done, 1'b0);
    send_frame(32'h05, 1);
    chk("restart_done", done, 1'b1);
    chk("restart_cnt", 32'(fifo_cnt), 32'd3);
    for (int i = 0; i < 3; i++) pop_chk("abort_pop");

    // tnum = 0 behaves as one frame
    do_reset();
    start_xfer(2'b00, 13'd0, 1'b0);
    send_frame(32'h77, 1);
    chk("tnum0_done", done, 1'b1);
    pop_chk("tnum0_pop");

    // tnum = 8191
    do_reset();
    start_xfer(2'b10, 13'd8191, 1'b0);
    for (int i = 0; i < 8190; i++) send_frame($urandom, 1);
    chk("tmax_nodone", done, 1'b0);
    chk("tmax_busy", busy, 1'b1);
    send_frame($urandom, 1);
    chk("tmax_done", done, 1'b1);
    chk("tmax_ovr", ovr, m_ovr);
    for (int i = 0; i < 4; i++) pop_chk("tmax_pop");

    // Reset mid-DATA with a push and pop in flight
    do_reset();
    start_xfer(2'b00, 13'd5, 1'b0);
    send_frame(32'hE1, 1);
    send_frame(32'hE2, 1);
    chk("midrst_cnt", 32'(fifo_cnt), 32'd2);
    spi_rx_rst = 1'b1; frame_vld = 1'b1; frame_data = 32'hE3; rd_en = 1'b1;
    tick();
    spi_rx_rst = 1'b0; frame_vld = 1'b0; frame_data = 32'h0; rd_en = 1'b0;
    q.delete();
    chk_all_zero("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx_ctrl.md
# spi_rx_ctrl

Receive-side transfer controller for the SPI slave/master receive path. Sequences one transfer of `spi_tnum_max` data frames plus an optional CRC frame coming out of the receive shifter, and buffers data frames in a small first-word-fall-through FIFO for the register interface. It raises the RXNE, overrun and CRC-error status flags, and pulses `done` at end of transfer. Sits between the receive shifter/CRC engine and the APB register block, in the receive clock domain.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, 2..16.
- `CW`, $clog2(FIFO_DEPTH)+1: width of `fifo_cnt` (derived, not overridden).

- `clk_rx`  in  1  receive clock; all logic on rising edge.
- `spi_rx_rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a transfer, sampled only in IDLE.
- `abort`  in  1  one-cycle pulse; terminates the transfer.
- `df`  in  2  frame width: 00 = 8 bit, 01 = 16 bit, 1x = 32 bit.
- `spi_tnum_max`  in  13  data frames per transfer; 0 treated as 1.
- `crc_en`  in  1  a CRC frame follows the data frames.
- `frame_vld`  in  1  one-cycle pulse: `frame_data` holds a completed frame.
- `frame_data`  in  32  received frame, right-aligned, upper bits zero.
- `crc_calc`  in  32  CRC computed locally over the data frames; valid whenever `frame_vld` is high.
- `rd_en`  in  1  pop the FIFO head.
- `ovr_clr`  in  1  clear `ovr`.
- `crcerr_clr`  in  1  clear `crcerr`.
- `rd_data`  out  32  FIFO head (fall-through); 32'h0 when empty.
- `rxne`  out  1  FIFO not empty.
- `fifo_cnt`  out  CW  entries held.
- `ovr`  out  1  sticky overrun.
- `crcerr`  out  1  sticky CRC mismatch.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle end-of-transfer pulse.

## Operation
- States: IDLE, DATA, CRC, DONE.
- Reset: state IDLE. All outputs 0, including `rd_data`. FIFO pointers and count 0, frame counter 0.
- IDLE and `start`: go to DATA.
  - Latch `df`, `crc_en` and the tnum value (0 becomes 1). Later changes to these inputs have no effect until the next `start`.
  - Clear the frame counter.
  - `start` outside IDLE is ignored.
- DATA and `frame_vld`: push `frame_data` to the FIFO and increment the 13-bit frame counter.
  - When the incremented count equals the latched tnum, go to CRC if latched `crc_en` = 1, else go to DONE.
- CRC and `frame_vld`: compare `frame_data` against `crc_calc` under a width mask (8 bits for df=00, 16 bits for df=01, 32 bits otherwise).
  - Mismatch sets `crcerr`.
  - The CRC frame is never pushed.
  - Go to DONE.
- DONE: `done` = 1 for exactly this one cycle; go to IDLE.
- `frame_vld` in IDLE or DONE is ignored: no push, no flag change.
- `abort` in DATA or CRC: go to IDLE on the next edge.
  - No `done`, no CRC check.
  - FIFO contents and flags are kept.
  - `abort` has priority over a coincident `frame_vld`: that frame is dropped and not counted.
- FIFO rules:
  - Push when full: data dropped, `ovr` set, pointers and count unchanged.
  - Push and pop in the same cycle when full: both succeed, `fifo_cnt` unchanged, no overrun.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flag rules:
  - `ovr` and `crcerr` are sticky.
  - Each clear input clears its own flag.
  - Set and clear in the same cycle: set wins.
  - Reset clears both.

## Timing
- `frame_vld` at edge N: entry visible at edge N+1 (`rxne`, `fifo_cnt` and `rd_data` all update at N+1).
- `rd_en` at edge N: head removed; `rd_data` shows the next entry, or 0, at N+1.
- `start` at N: `busy` = 1 from N+1.
- Last data frame at N with `crc_en` = 0: state DONE at N+1 with `done` = 1, `busy` = 0 at N+2.
- CRC frame at N: `crcerr` valid at N+1, `done` at N+1.
- `abort` at N: `busy` = 0 at N+1.
- `spi_rx_rst` asserted on any edge overrides everything, including an in-flight frame, push or pop. All state returns to the reset values at the next edge.
- `rd_data` is a combinational mux of the head entry; all other outputs are registered.

## Test plan
- Basic transfer: df=00, tnum=3, crc_en=0, frames 0xA1/0xB2/0xC3 -> `fifo_cnt`=3, `done` one cycle after the third frame. Three pops return A1, B2, C3, then `rxne`=0 and `rd_data`=0.
- CRC check: df=01, tnum=2, crc_en=1, `crc_calc`=0x1234.
  - CRC frame 0x1234 -> `crcerr`=0, FIFO holds 2 entries.
  - Repeat with CRC frame 0x1235 -> `crcerr`=1 until `crcerr_clr`.
  - df=00 with `crc_calc`=0xFF34 and frame 0x34 -> match.
- Overrun: FIFO_DEPTH=4, tnum=6, no pops -> `ovr`=1 after the 5th frame, `fifo_cnt`=4, contents are frames 1..4. A push and pop in the same cycle at full gives no overrun.
- Abort: `abort` coincident with the 2nd of tnum=4 frames -> `busy`=0 next cycle, `fifo_cnt`=1, no `done`. `frame_vld` afterwards is ignored. A new `start` counts from 0.
- Boundaries:
  - tnum=0 -> one frame completes the transfer.
  - tnum=8191 completes after exactly 8191 frames.
  - `ovr_clr` coincident with overrun -> `ovr` stays 1.
  - Synchronous reset mid-DATA with 2 entries -> all outputs 0 next cycle.
